// File: rtl/maquina_estados.sv
// Global control FSM for the 4x4 FIFO router: drives the arbiters' state bus,
// holds the FIFO thresholds, and flags idleness and FIFO errors.
module maquina_estados #(
    parameter int UMBRAL_W = 4,
    parameter int DEF_ALTO = 3,
    parameter int DEF_BAJO = 1,
    parameter int IDLE_CYC = 2
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                init,
    input  logic [UMBRAL_W-1:0] umbral_alto_in,
    input  logic [UMBRAL_W-1:0] umbral_bajo_in,
    input  logic [7:0]          fifo_empty,
    input  logic [7:0]          fifo_error,
    output logic [3:0]          state,
    output logic [UMBRAL_W-1:0] umbral_alto,
    output logic [UMBRAL_W-1:0] umbral_bajo,
    output logic                idle,
    output logic                error_out,
    output logic [2:0]          error_id
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_INIT   = 4'd1,
        ST_IDLE   = 4'd2,
        ST_ACTIVE = 4'd3,
        ST_ERROR  = 4'd4
    } state_t;

    localparam logic [UMBRAL_W-1:0] ALTO_RST = UMBRAL_W'(DEF_ALTO);
    localparam logic [UMBRAL_W-1:0] BAJO_RST = UMBRAL_W'(DEF_BAJO);
    localparam logic [4:0]          IDLE_LIM = 5'(IDLE_CYC);

    state_t       state_q, state_d;
    logic [3:0]   idle_cnt_q, idle_cnt_d;
    logic [2:0]   error_id_d;
    logic         idle_d, error_out_d;
    logic         load_thr;
    logic         thr_ok;
    logic         all_empty;
    logic         any_error;
    logic         idle_reached;

    // Priority encoder: the lowest-numbered FIFO reporting an error wins.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign thr_ok       = (umbral_bajo_in < umbral_alto_in);
    assign all_empty    = (fifo_empty == 8'hFF);
    assign any_error    = (fifo_error != 8'h00);
    assign idle_reached = ({1'b0, idle_cnt_q} + 5'd1 >= IDLE_LIM);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = 4'd0;
        error_id_d  = error_id;
        load_thr    = 1'b0;

        unique case (state_q)
            ST_RESET: state_d = ST_INIT;

            ST_INIT: begin
                load_thr = thr_ok;
                if (!init && thr_ok) state_d = ST_IDLE;
            end

            ST_IDLE: begin
                if (any_error)       state_d = ST_ERROR;
                else if (init)       state_d = ST_INIT;
                else if (!all_empty) state_d = ST_ACTIVE;
            end

            ST_ACTIVE: begin
                if (any_error) begin
                    state_d = ST_ERROR;
                end else if (init) begin
                    state_d = ST_INIT;
                end else if (all_empty) begin
                    if (idle_reached) state_d = ST_IDLE;
                    else idle_cnt_d = (idle_cnt_q == 4'hF) ? idle_cnt_q : idle_cnt_q + 4'd1;
                end
            end

            ST_ERROR: state_d = ST_ERROR;

            // Encodings 5..15 should never occur; recover through RESET.
            default: state_d = ST_RESET;
        endcase

        if (state_d == ST_ERROR && state_q != ST_ERROR) error_id_d = lowest_set(fifo_error);

        idle_d      = (state_d == ST_IDLE) && all_empty;
        error_out_d = (state_d == ST_ERROR);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= ST_RESET;
            idle_cnt_q  <= 4'd0;
            umbral_alto <= ALTO_RST;
            umbral_bajo <= BAJO_RST;
            idle        <= 1'b0;
            error_out   <= 1'b0;
            error_id    <= 3'd0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            idle       <= idle_d;
            error_out  <= error_out_d;
            error_id   <= error_id_d;
            if (load_thr) begin
                umbral_alto <= umbral_alto_in;
                umbral_bajo <= umbral_bajo_in;
            end
        end
    end

    assign state = state_q;

endmodule
